// File: rtl/bu_nested_pkg.sv
// Shared types and constants for the branch/trap resolution unit.
`ifndef PRIV_ROUTINE_START
`define PRIV_ROUTINE_START 64'h0000_0000_8000_0000
`endif

package bu_nested_pkg;

  localparam logic [63:0] PRIV_BASE_DEFAULT = `PRIV_ROUTINE_START;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JAL    = 3'd2,
    OP_JALR   = 3'd3,
    OP_AUIPC  = 3'd4,
    OP_ECALL  = 3'd5,
    OP_ERET   = 3'd6
  } op_kind_t;

  // imm carries the raw immediate; each op sign-extends its own field width
  typedef struct packed {
    op_kind_t    kind;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } op_t;

  typedef enum logic {
    CPL_USER       = 1'b0,
    CPL_SUPERVISOR = 1'b1
  } cpl_t;

  typedef enum logic [2:0] {
    FAULT_NONE          = 3'd0,
    FAULT_ILLEGAL_JUMP  = 3'd1,
    FAULT_RAS_OVERFLOW  = 3'd2,
    FAULT_RAS_UNDERFLOW = 3'd3,
    FAULT_MISALIGNED    = 3'd4
  } bu_fault_t;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

endpackage

// File: rtl/bu_nested_if.sv
// Execute-stage bus between the pipeline (master) and the resolution unit (slave).
interface bu_nested_if
  import bu_nested_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RET_DEPTH  = 4
) ();

  logic [DATA_WIDTH-1:0]      lhs;
  logic [DATA_WIDTH-1:0]      rhs;
  logic                       lhs_valid;
  logic                       rhs_valid;
  logic                       retire;
  op_t                        op_spec;
  logic [DATA_WIDTH-1:0]      pc;
  logic [DATA_WIDTH-1:0]      result_pc;
  logic [DATA_WIDTH-1:0]      result_rd;
  logic                       result_pc_valid;
  logic                       result_rd_valid;
  logic                       taken_o;
  logic                       done_o;
  cpl_t                       cpl_o;
  logic [$clog2(RET_DEPTH):0] depth_o;
  logic                       fault_o;
  bu_fault_t                  fault_cause_o;

  modport master (
    output lhs, rhs, lhs_valid, rhs_valid, retire, op_spec, pc,
    input  result_pc, result_rd, result_pc_valid, result_rd_valid,
           taken_o, done_o, cpl_o, depth_o, fault_o, fault_cause_o
  );

  modport slave (
    input  lhs, rhs, lhs_valid, rhs_valid, retire, op_spec, pc,
    output result_pc, result_rd, result_pc_valid, result_rd_valid,
           taken_o, done_o, cpl_o, depth_o, fault_o, fault_cause_o
  );

endinterface

// File: rtl/bu_nested_ras.sv
// Return-address LIFO; occupancy doubles as the write pointer, entries survive pops.
module bu_ras #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    ptr_reg;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign wr_idx  = ptr_reg[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign full    = (ptr_reg == DW'(DEPTH));
  assign empty   = (ptr_reg == '0);
  assign depth   = ptr_reg;
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (push && !full) begin
      ptr_reg <= ptr_reg + DW'(1);
    end else if (pop && !empty) begin
      ptr_reg <= ptr_reg - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/bu_nested.sv
// Branch/trap resolution: combinational next-pc/link with nested-ECALL return stack and CPL.
module bu_nested
  import bu_nested_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    RET_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] PRIV_BASE  = DATA_WIDTH'(PRIV_BASE_DEFAULT)
) (
  input logic         clk,
  input logic         rst,
  bu_nested_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_raw, rd_raw, pc_plus4, imm_b, imm_j, imm_i, imm_u, jalr_sum;
  logic                  pc_has, rd_has, taken, done, is_ecall, is_eret, cond;
  logic                  ras_full, ras_empty, push, pop;
  logic [DATA_WIDTH-1:0] ras_top;
  logic [$clog2(RET_DEPTH):0] ras_depth;
  bu_fault_t             cause;
  cpl_t                  cpl_reg;

  assign pc_plus4 = bus.pc + FOUR;
  assign imm_b    = DATA_WIDTH'($signed(bus.op_spec.imm[12:0]));
  assign imm_j    = DATA_WIDTH'($signed(bus.op_spec.imm[20:0]));
  assign imm_i    = DATA_WIDTH'($signed(bus.op_spec.imm[11:0]));
  assign imm_u    = DATA_WIDTH'($signed(bus.op_spec.imm));
  assign jalr_sum = bus.lhs + imm_i;

  always_comb begin
    pc_raw   = 'x;
    rd_raw   = 'x;
    pc_has   = 1'b0;
    rd_has   = 1'b0;
    taken    = 1'b0;
    done     = 1'b0;
    is_ecall = 1'b0;
    is_eret  = 1'b0;
    cond     = 1'b0;
    case (bus.op_spec.kind)
      OP_BRANCH: begin
        done   = bus.lhs_valid && bus.rhs_valid;
        pc_has = 1'b1;
        case (bus.op_spec.funct3)
          F3_BEQ:  cond = (bus.lhs == bus.rhs);
          F3_BNE:  cond = (bus.lhs != bus.rhs);
          F3_BLT:  cond = ($signed(bus.lhs) <  $signed(bus.rhs));
          F3_BGE:  cond = ($signed(bus.lhs) >= $signed(bus.rhs));
          F3_BLTU: cond = (bus.lhs <  bus.rhs);
          F3_BGEU: cond = (bus.lhs >= bus.rhs);
          default: cond = 1'b0;
        endcase
        taken  = cond;
        pc_raw = cond ? (bus.pc + imm_b) : pc_plus4;
      end
      OP_JAL: begin
        done   = 1'b1;
        pc_has = 1'b1;
        rd_has = 1'b1;
        taken  = 1'b1;
        pc_raw = bus.pc + imm_j;
        rd_raw = pc_plus4;
      end
      OP_JALR: begin
        done   = bus.lhs_valid;
        pc_has = 1'b1;
        rd_has = 1'b1;
        taken  = 1'b1;
        pc_raw = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
        rd_raw = pc_plus4;
      end
      OP_AUIPC: begin
        done   = 1'b1;
        rd_has = 1'b1;
        rd_raw = bus.pc + imm_u;
      end
      OP_ECALL: begin
        done     = 1'b1;
        pc_has   = 1'b1;
        taken    = 1'b1;
        is_ecall = 1'b1;
        pc_raw   = PRIV_BASE;
      end
      OP_ERET: begin
        done    = 1'b1;
        pc_has  = 1'b1;
        taken   = 1'b1;
        is_eret = 1'b1;
        pc_raw  = ras_top;
      end
      default: ;
    endcase
  end

  // Stack faults outrank target checks; the ECALL entry point itself is always legal.
  always_comb begin
    cause = FAULT_NONE;
    if (done) begin
      if (is_ecall && ras_full)
        cause = FAULT_RAS_OVERFLOW;
      else if (is_eret && ras_empty)
        cause = FAULT_RAS_UNDERFLOW;
      else if (pc_has && (pc_raw >= PRIV_BASE) && !is_ecall && (cpl_reg == CPL_USER))
        cause = FAULT_ILLEGAL_JUMP;
      else if (pc_has && (pc_raw[1:0] != 2'b00))
        cause = FAULT_MISALIGNED;
    end
  end

  assign bus.result_pc       = pc_raw;
  assign bus.result_rd       = rd_raw;
  assign bus.fault_o         = (cause != FAULT_NONE);
  assign bus.fault_cause_o   = cause;
  assign bus.done_o          = done;
  assign bus.taken_o         = done && taken;
  assign bus.result_pc_valid = done && pc_has && (cause == FAULT_NONE);
  assign bus.result_rd_valid = done && rd_has && (cause == FAULT_NONE);
  assign bus.cpl_o           = cpl_reg;
  assign bus.depth_o         = ras_depth;

  assign push = bus.retire && done && (cause == FAULT_NONE) && is_ecall;
  assign pop  = bus.retire && done && (cause == FAULT_NONE) && is_eret;

  bu_ras #(
    .DEPTH (RET_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .depth     (ras_depth),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpl_reg <= CPL_USER;
    end else if (push) begin
      cpl_reg <= CPL_SUPERVISOR;
    end else if (pop && (ras_depth == ($clog2(RET_DEPTH)+1)'(1))) begin
      cpl_reg <= CPL_USER;
    end
  end

  a_retire_resolved: assert property (@(posedge clk) disable iff (rst) bus.retire |-> bus.done_o);

endmodule

// File: tb/tb_bu_nested.sv
// Directed-vector bench for bu_nested: branches, jumps, nested ECALL/ERET, stack limits, reset.
module tb_bu_nested;
  import bu_nested_pkg::*;

  localparam logic [63:0] PB = PRIV_BASE_DEFAULT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bu_nested_if #(.DATA_WIDTH(64), .RET_DEPTH(4)) bus ();

  bu_nested #(.DATA_WIDTH(64), .RET_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drive(input op_kind_t k, input logic [2:0] f3, input logic [31:0] imm,
                       input logic [63:0] p, input logic [63:0] l, input logic [63:0] r,
                       input logic lv, input logic rv);
    @(negedge clk);
    bus.op_spec   = '{kind: k, funct3: f3, imm: imm};
    bus.pc        = p;
    bus.lhs       = l;
    bus.rhs       = r;
    bus.lhs_valid = lv;
    bus.rhs_valid = rv;
    #1;
  endtask

  task automatic do_retire();
    bus.retire = 1'b1;
    @(posedge clk);
    #1;
    bus.retire = 1'b0;
  endtask

  task automatic test_reset();
    drive(OP_NONE, 3'd0, 32'd0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    n_vec++; if (bus.depth_o !== 3'd0) begin n_err++; $display("FAIL reset_depth got %0d want 0", bus.depth_o); end
    n_vec++; if (bus.cpl_o !== CPL_USER) begin n_err++; $display("FAIL reset_cpl got %0d want %0d", bus.cpl_o, CPL_USER); end
    n_vec++; if (bus.done_o !== 1'b0 || bus.fault_o !== 1'b0) begin n_err++; $display("FAIL reset_idle got done=%b fault=%b want done=0 fault=0", bus.done_o, bus.fault_o); end
    $display("test_reset: depth=%0d cpl=%0d", bus.depth_o, bus.cpl_o);
  endtask

  task automatic test_branch();
    drive(OP_BRANCH, F3_BEQ, 32'd16, 64'h100, 64'd5, 64'd5, 1'b1, 1'b0);
    n_vec++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL beq_wait_rhs got done=%b want 0", bus.done_o); end
    drive(OP_BRANCH, F3_BEQ, 32'd16, 64'h100, 64'd5, 64'd5, 1'b1, 1'b1);
    n_vec++; if (bus.result_pc !== 64'h110) begin n_err++; $display("FAIL beq_pc got %0h want 110", bus.result_pc); end
    n_vec++; if ({bus.taken_o, bus.done_o, bus.fault_o, bus.result_pc_valid} !== 4'b1101) begin n_err++; $display("FAIL beq_flags got %b want 1101", {bus.taken_o, bus.done_o, bus.fault_o, bus.result_pc_valid}); end
    $display("test_branch BEQ: pc=%0h taken=%b", bus.result_pc, bus.taken_o);
    drive(OP_BRANCH, F3_BLT, 32'd16, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
    n_vec++; if (bus.result_pc !== 64'h110 || bus.taken_o !== 1'b1) begin n_err++; $display("FAIL blt got pc=%0h taken=%b want pc=110 taken=1", bus.result_pc, bus.taken_o); end
    $display("test_branch BLT: pc=%0h taken=%b", bus.result_pc, bus.taken_o);
    drive(OP_BRANCH, F3_BLTU, 32'd16, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
    n_vec++; if (bus.result_pc !== 64'h104 || bus.taken_o !== 1'b0) begin n_err++; $display("FAIL bltu got pc=%0h taken=%b want pc=104 taken=0", bus.result_pc, bus.taken_o); end
    $display("test_branch BLTU: pc=%0h taken=%b", bus.result_pc, bus.taken_o);
    drive(OP_BRANCH, F3_BGE, 32'h1FF0, 64'h100, 64'd3, 64'd3, 1'b1, 1'b1);
    n_vec++; if (bus.result_pc !== 64'hF0 || bus.taken_o !== 1'b1) begin n_err++; $display("FAIL bge_back got pc=%0h taken=%b want pc=f0 taken=1", bus.result_pc, bus.taken_o); end
    $display("test_branch BGE back: pc=%0h taken=%b", bus.result_pc, bus.taken_o);
  endtask

  task automatic test_jumps();
    drive(OP_JALR, 3'd0, 32'd4, 64'h100, PB - 64'd4, 64'd0, 1'b1, 1'b0);
    n_vec++; if (bus.fault_o !== 1'b1 || bus.fault_cause_o !== FAULT_ILLEGAL_JUMP) begin n_err++; $display("FAIL jalr_illegal got fault=%b cause=%0d want 1/%0d", bus.fault_o, bus.fault_cause_o, FAULT_ILLEGAL_JUMP); end
    n_vec++; if (bus.result_pc_valid !== 1'b0 || bus.result_rd_valid !== 1'b0 || bus.done_o !== 1'b1) begin n_err++; $display("FAIL jalr_illegal_valid got pcv=%b rdv=%b done=%b want 0 0 1", bus.result_pc_valid, bus.result_rd_valid, bus.done_o); end
    do_retire();
    n_vec++; if (bus.depth_o !== 3'd0 || bus.cpl_o !== CPL_USER) begin n_err++; $display("FAIL jalr_fault_retire got depth=%0d cpl=%0d want 0/0", bus.depth_o, bus.cpl_o); end
    $display("test_jumps JALR illegal: cause=%0d depth=%0d", bus.fault_cause_o, bus.depth_o);
    drive(OP_JALR, 3'd0, 32'h005, 64'h100, 64'h2000, 64'd0, 1'b1, 1'b0);
    n_vec++; if (bus.result_pc !== 64'h2004 || bus.result_rd !== 64'h104 || bus.result_rd_valid !== 1'b1) begin n_err++; $display("FAIL jalr_ok got pc=%0h rd=%0h rdv=%b want 2004 104 1", bus.result_pc, bus.result_rd, bus.result_rd_valid); end
    drive(OP_JAL, 3'd0, 32'd2, 64'h100, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.fault_cause_o !== FAULT_MISALIGNED || bus.result_rd_valid !== 1'b0) begin n_err++; $display("FAIL jal_misaligned got cause=%0d rdv=%b want %0d 0", bus.fault_cause_o, bus.result_rd_valid, FAULT_MISALIGNED); end
    $display("test_jumps JAL +2: cause=%0d", bus.fault_cause_o);
    drive(OP_JAL, 3'd0, 32'd8, 64'h100, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.result_pc !== 64'h108 || bus.result_rd !== 64'h104 || bus.fault_o !== 1'b0) begin n_err++; $display("FAIL jal_ok got pc=%0h rd=%0h fault=%b want 108 104 0", bus.result_pc, bus.result_rd, bus.fault_o); end
    drive(OP_AUIPC, 3'd0, 32'h1000, 64'h100, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.result_rd !== 64'h1100 || bus.result_pc_valid !== 1'b0 || bus.taken_o !== 1'b0) begin n_err++; $display("FAIL auipc got rd=%0h pcv=%b taken=%b want 1100 0 0", bus.result_rd, bus.result_pc_valid, bus.taken_o); end
    $display("test_jumps AUIPC: rd=%0h", bus.result_rd);
  endtask

  task automatic test_nested();
    drive(OP_ECALL, 3'd0, 32'd0, 64'h200, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.result_pc !== PB || bus.taken_o !== 1'b1 || bus.fault_o !== 1'b0) begin n_err++; $display("FAIL ecall got pc=%0h taken=%b fault=%b want %0h 1 0", bus.result_pc, bus.taken_o, bus.fault_o, PB); end
    do_retire();
    drive(OP_ECALL, 3'd0, 32'd0, 64'h300, 64'd0, 64'd0, 1'b0, 1'b0);
    do_retire();
    n_vec++; if (bus.depth_o !== 3'd2 || bus.cpl_o !== CPL_SUPERVISOR) begin n_err++; $display("FAIL nest2 got depth=%0d cpl=%0d want 2/1", bus.depth_o, bus.cpl_o); end
    $display("test_nested: two ECALLs depth=%0d cpl=%0d", bus.depth_o, bus.cpl_o);
    drive(OP_ERET, 3'd0, 32'd0, 64'h8000_0040, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.result_pc !== 64'h304 || bus.result_pc_valid !== 1'b1) begin n_err++; $display("FAIL eret1_pc got %0h pcv=%b want 304 1", bus.result_pc, bus.result_pc_valid); end
    do_retire();
    n_vec++; if (bus.depth_o !== 3'd1 || bus.cpl_o !== CPL_SUPERVISOR) begin n_err++; $display("FAIL eret1_state got depth=%0d cpl=%0d want 1/1", bus.depth_o, bus.cpl_o); end
    drive(OP_ERET, 3'd0, 32'd0, 64'h8000_0080, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.result_pc !== 64'h204) begin n_err++; $display("FAIL eret2_pc got %0h want 204", bus.result_pc); end
    do_retire();
    n_vec++; if (bus.depth_o !== 3'd0 || bus.cpl_o !== CPL_USER) begin n_err++; $display("FAIL eret2_state got depth=%0d cpl=%0d want 0/0", bus.depth_o, bus.cpl_o); end
    $display("test_nested: unwound depth=%0d cpl=%0d", bus.depth_o, bus.cpl_o);
  endtask

  task automatic test_stack_limits();
    logic [63:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      drive(OP_ECALL, 3'd0, 32'd0, 64'h400 + 64'(16 * i), 64'd0, 64'd0, 1'b0, 1'b0);
      do_retire();
    end
    n_vec++; if (bus.depth_o !== 3'd4) begin n_err++; $display("FAIL fill_depth got %0d want 4", bus.depth_o); end
    drive(OP_ECALL, 3'd0, 32'd0, 64'h8000_0100, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.fault_cause_o !== FAULT_RAS_OVERFLOW || bus.done_o !== 1'b1 || bus.result_pc_valid !== 1'b0) begin n_err++; $display("FAIL overflow got cause=%0d done=%b pcv=%b want %0d 1 0", bus.fault_cause_o, bus.done_o, bus.result_pc_valid, FAULT_RAS_OVERFLOW); end
    do_retire();
    n_vec++; if (bus.depth_o !== 3'd4) begin n_err++; $display("FAIL overflow_depth got %0d want 4", bus.depth_o); end
    $display("test_stack_limits: overflow cause=%0d depth=%0d", bus.fault_cause_o, bus.depth_o);
    for (int i = 3; i >= 0; i--) begin
      exp_pc = 64'h404 + 64'(16 * i);
      drive(OP_ERET, 3'd0, 32'd0, 64'h8000_0200, 64'd0, 64'd0, 1'b0, 1'b0);
      n_vec++; if (bus.result_pc !== exp_pc) begin n_err++; $display("FAIL pop%0d got %0h want %0h", i, bus.result_pc, exp_pc); end
      do_retire();
    end
    drive(OP_ERET, 3'd0, 32'd0, 64'h100, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.fault_cause_o !== FAULT_RAS_UNDERFLOW || bus.fault_o !== 1'b1) begin n_err++; $display("FAIL underflow got cause=%0d fault=%b want %0d 1", bus.fault_cause_o, bus.fault_o, FAULT_RAS_UNDERFLOW); end
    do_retire();
    n_vec++; if (bus.depth_o !== 3'd0 || bus.cpl_o !== CPL_USER) begin n_err++; $display("FAIL underflow_state got depth=%0d cpl=%0d want 0/0", bus.depth_o, bus.cpl_o); end
    $display("test_stack_limits: underflow cause=%0d", bus.fault_cause_o);
  endtask

  task automatic test_reset_mid();
    drive(OP_ECALL, 3'd0, 32'd0, 64'h500, 64'd0, 64'd0, 1'b0, 1'b0);
    do_retire();
    n_vec++; if (bus.depth_o !== 3'd1) begin n_err++; $display("FAIL pre_reset_depth got %0d want 1", bus.depth_o); end
    drive(OP_ECALL, 3'd0, 32'd0, 64'h600, 64'd0, 64'd0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    n_vec++; if (bus.depth_o !== 3'd0 || bus.cpl_o !== CPL_USER) begin n_err++; $display("FAIL async_reset got depth=%0d cpl=%0d want 0/0", bus.depth_o, bus.cpl_o); end
    rst = 1'b0;
    drive(OP_ERET, 3'd0, 32'd0, 64'h100, 64'd0, 64'd0, 1'b0, 1'b0);
    n_vec++; if (bus.fault_cause_o !== FAULT_RAS_UNDERFLOW) begin n_err++; $display("FAIL post_reset_eret got cause=%0d want %0d", bus.fault_cause_o, FAULT_RAS_UNDERFLOW); end
    $display("test_reset_mid: depth=%0d eret cause=%0d", bus.depth_o, bus.fault_cause_o);
  endtask

  initial begin
    bus.retire    = 1'b0;
    bus.op_spec   = '{kind: OP_NONE, funct3: 3'd0, imm: 32'd0};
    bus.pc        = '0;
    bus.lhs       = '0;
    bus.rhs       = '0;
    bus.lhs_valid = 1'b0;
    bus.rhs_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_branch();
    test_jumps();
    test_nested();
    test_stack_limits();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
